// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
//   Shared types for the multi-slave SPI master.
//   - spi_state_e : master sequencer states (IDLE, SETUP, TRANSFER, HOLD)
//   - spi_mode_t  : latched {cpol, cpha} pair for one transfer
//   - edge_cnt_width() : width of the SCLK edge counter for a word width
// Configuration macro used by the master: SPI_LSB_FIRST_EN.
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // A transfer of N bits spans 2*N SCLK edges, numbered 0 .. 2*N-1.
    function automatic int unsigned edge_cnt_width(input int unsigned data_width);
        return $clog2(2 * data_width);
    endfunction

    localparam int unsigned SPI_DEFAULT_EDGE_CNT_W = edge_cnt_width(8);

endpackage : spi_pkg

// File: rtl/spi_clk_div.sv
// ----------------------------------------------------------------------------
// spi_clk_div
//   Half-period timer for the SPI master. While enabled, tick_o pulses for one
//   clock every div_i+1 clocks; load_i clears the counter so the next step
//   starts a full half-period.
// Ports
//   clk_i   in  system clock
//   rst_i   in  asynchronous active-high reset
//   load_i  in  clear counter (has priority over en_i)
//   en_i    in  count enable
//   div_i   in  half-period minus one (wrap value)
//   tick_o  out one-cycle pulse at the end of each half-period
// ----------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : spi_clk_div

// File: rtl/spi_master_multi.sv
// ----------------------------------------------------------------------------
// spi_master_multi
//   Parametrised SPI master: configurable word width, NUM_SS one-hot decoded
//   active-low selects, per-transfer CPOL/CPHA and a busy/done handshake.
//   Sequence IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE, each non-IDLE step one
//   SCLK half-period (clock_div+1 clocks).
// Ports
//   clock, reset       system clock, asynchronous active-high reset
//   start              transfer request, sampled only in IDLE
//   dataToTransmit     word to send (latched on start)
//   ss_sel             target slave index (latched; out of range = no select)
//   cpol, cpha         SPI mode (latched on start)
//   clock_div          SCLK half-period minus one (latched on start)
//   lsb_first          only with SPI_LSB_FIRST_EN: send/receive LSB first
//   MISO               serial data from slave
//   sclk, ss_n, MOSI   SPI bus outputs
//   busy               high while not IDLE
//   done               one-cycle pulse in the first IDLE cycle after a transfer
//   dataRecieved       last received word, updated together with done
// Configuration macro: SPI_LSB_FIRST_EN (undefined: MSB first, no lsb_first).
// ----------------------------------------------------------------------------
module spi_master_multi
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NUM_SS     = 4,
    parameter  int unsigned DIV_WIDTH  = 8,
    localparam int unsigned SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dataToTransmit,
    input  logic [SS_W-1:0]       ss_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clock_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    input  logic                  MISO,
    output logic                  sclk,
    output logic [NUM_SS-1:0]     ss_n,
    output logic                  MOSI,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dataRecieved
);

    localparam int unsigned ECW = edge_cnt_width(DATA_WIDTH);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    spi_mode_t             mode_q, mode_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SS_W-1:0]       sel_q, sel_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [ECW-1:0]        edge_q, edge_d;
    logic                  sclk_q, sclk_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  lsb_mode;
    logic                  leading;
    logic                  do_sample;
    logic                  do_shift;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign lsb_mode = lsb_q;
`else
    assign lsb_mode = 1'b0;
`endif

    spi_clk_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_div (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (state_q == IDLE),
        .en_i   (state_q != IDLE),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        sel_d     = sel_q;
        div_d     = div_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_d     = lsb_q;
`endif
        leading   = ~edge_q[0];
        // cpha=0 samples on leading edges, cpha=1 on trailing edges.
        do_sample = leading ^ mode_q.cpha;
        // MOSI already holds the first bit from SETUP, so cpha=1 skips the
        // shift on edge 0 and cpha=0 skips it after the final trailing edge.
        do_shift  = mode_q.cpha ? (leading && (edge_q != '0))
                                : (!leading && (edge_q != LAST_EDGE));

        unique case (state_q)
            IDLE: begin
                sclk_d = mode_q.cpol;
                if (start) begin
                    mode_d  = '{cpol: cpol, cpha: cpha};
                    tx_d    = dataToTransmit;
                    rx_d    = '0;
                    sel_d   = ss_sel;
                    div_d   = clock_div;
                    edge_d  = '0;
                    sclk_d  = cpol;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (do_sample) begin
                        rx_d = lsb_mode ? {MISO, rx_q[DATA_WIDTH-1:1]}
                                        : {rx_q[DATA_WIDTH-2:0], MISO};
                    end
                    if (do_shift) begin
                        tx_d = lsb_mode ? {1'b0, tx_q[DATA_WIDTH-1:1]}
                                        : {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = HOLD;
                    end else begin
                        edge_d = edge_q + ECW'(1);
                    end
                end
            end
            HOLD: begin
                sclk_d = mode_q.cpol;
                if (tick) begin
                    done_d  = 1'b1;
                    data_d  = rx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q   <= lsb_d;
`endif
        end
    end

    // Select decode follows the state directly so reset releases it at once;
    // an out-of-range index matches no bit and leaves every select high.
    always_comb begin
        ss_n = '1;
        if (state_q != IDLE) begin
            for (int unsigned i = 0; i < NUM_SS; i++) begin
                if (sel_q == SS_W'(i)) begin
                    ss_n[i] = 1'b0;
                end
            end
        end
    end

    assign MOSI         = (state_q != IDLE) ? (lsb_mode ? tx_q[0] : tx_q[DATA_WIDTH-1]) : 1'b0;
    assign sclk         = sclk_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign dataRecieved = data_q;

endmodule : spi_master_multi

// File: tb/tb_spi_master_multi.sv
// ----------------------------------------------------------------------------
// tb_spi_master_multi
//   Directed bench for spi_master_multi with a mode-aware behavioural slave.
//   A second instance (NUM_SS=3, ss_sel fixed at 3) runs every transfer in
//   parallel to cover the out-of-range select.
//   Honours SPI_LSB_FIRST_EN for the LSB-first vector.
// ----------------------------------------------------------------------------
module tb_spi_master_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dataToTransmit = '0;
    logic [1:0] ss_sel = '0;
    logic [1:0] ss_sel3 = 2'd3;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clock_div = '0;
    logic       MISO = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first = 1'b0;
`endif

    logic       sclk, MOSI, busy, done;
    logic [3:0] ss_n;
    logic [7:0] dataRecieved;
    logic       sclk3, MOSI3, busy3, done3;
    logic [2:0] ss_n3;
    logic [7:0] dataRecieved3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spi_master_multi #(
        .DATA_WIDTH (8),
        .NUM_SS     (4),
        .DIV_WIDTH  (8)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .dataToTransmit (dataToTransmit),
        .ss_sel         (ss_sel),
        .cpol           (cpol),
        .cpha           (cpha),
        .clock_div      (clock_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first      (lsb_first),
`endif
        .MISO           (MISO),
        .sclk           (sclk),
        .ss_n           (ss_n),
        .MOSI           (MOSI),
        .busy           (busy),
        .done           (done),
        .dataRecieved   (dataRecieved)
    );

    spi_master_multi #(
        .DATA_WIDTH (8),
        .NUM_SS     (3),
        .DIV_WIDTH  (8)
    ) u_dut3 (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .dataToTransmit (dataToTransmit),
        .ss_sel         (ss_sel3),
        .cpol           (cpol),
        .cpha           (cpha),
        .clock_div      (clock_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first      (lsb_first),
`endif
        .MISO           (MISO),
        .sclk           (sclk3),
        .ss_n           (ss_n3),
        .MOSI           (MOSI3),
        .busy           (busy3),
        .done           (done3),
        .dataRecieved   (dataRecieved3)
    );

    // ------------------------------------------------------------------
    // Behavioural slave, driven only by the main instance's bus.
    // ------------------------------------------------------------------
    logic       cpol_tb = 1'b0;
    logic       cpha_tb = 1'b0;
    logic       lsb_tb  = 1'b0;
    logic [7:0] slv_tx  = '0;
    logic [7:0] s_out   = '0;
    logic [7:0] s_in    = '0;
    logic       sel;
    logic       lead;
    int         ecnt = 0;

    assign sel = ~(&ss_n);

    always @(sel) begin
        if (sel) begin
            ecnt  = 0;
            s_in  = '0;
            s_out = slv_tx;
            if (!cpha_tb) MISO = lsb_tb ? s_out[0] : s_out[7];
        end
    end

    // Only alternating leading/trailing edges count, so the idle-level
    // change at the start of a transfer is ignored.
    always @(sclk) begin
        if (sel) begin
            lead = (sclk != cpol_tb);
            if ((lead && (ecnt % 2 == 0)) || (!lead && (ecnt % 2 == 1))) begin
                if (lead ^ cpha_tb) begin
                    s_in = lsb_tb ? {MOSI, s_in[7:1]} : {s_in[6:0], MOSI};
                end else if (cpha_tb) begin
                    MISO  = lsb_tb ? s_out[0] : s_out[7];
                    s_out = lsb_tb ? (s_out >> 1) : (s_out << 1);
                end else begin
                    s_out = lsb_tb ? (s_out >> 1) : (s_out << 1);
                    MISO  = lsb_tb ? s_out[0] : s_out[7];
                end
                ecnt++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after the start-sampling edge; n counts that edge as 1.
    task automatic wait_done(input logic [3:0] exp_ss, output int n, output int bad);
        n   = 1;
        bad = 0;
        while (!done && n < 4000) begin
            if (busy ? (ss_n !== exp_ss) : (ss_n !== 4'hF)) bad++;
            if (ss_n3 !== 3'b111) bad++;
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic xfer(input string tag, input logic pol, input logic pha,
                        input logic [7:0] div, input logic [7:0] tx,
                        input logic [7:0] srx, input logic [1:0] sel_idx);
        int n;
        int bad;
        logic [3:0] exp_ss;
        exp_ss = ~(4'b0001 << sel_idx);
        @(negedge clock);
        cpol = pol; cpha = pha; clock_div = div; dataToTransmit = tx; ss_sel = sel_idx;
        cpol_tb = pol; cpha_tb = pha; slv_tx = srx;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq({tag, " busy after start"}, busy, 1'b1);
        // Inputs are latched; scrambling them must not disturb the transfer.
        cpol = ~pol; cpha = ~pha; clock_div = div + 8'd5; dataToTransmit = ~tx; ss_sel = sel_idx + 2'd1;
        wait_done(exp_ss, n, bad);
        check_eq({tag, " latency"}, n, (div + 1) * 18 + 1);
        check_eq({tag, " rx"}, dataRecieved, srx);
        check_eq({tag, " slave rx"}, s_in, tx);
        check_eq({tag, " ss_n"}, bad, 0);
        check_eq({tag, " sclk idle"}, sclk, pol);
        check_eq({tag, " oor done"}, done3, 1'b1);
        check_eq({tag, " oor rx"}, dataRecieved3, srx);
        @(posedge clock); #1;
        check_eq({tag, " done pulse"}, done, 1'b0);
    endtask

    initial begin : main
        int n;
        int bad;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst sclk", sclk, 1'b0);
        check_eq("rst ss_n", ss_n, 4'hF);
        check_eq("rst mosi", MOSI, 1'b0);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst data", dataRecieved, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        xfer("m0", 1'b0, 1'b0, 8'd2, 8'hAA, 8'h6D, 2'd0);
        xfer("m1", 1'b0, 1'b1, 8'd1, 8'h3C, 8'hC3, 2'd1);
        xfer("m2", 1'b1, 1'b0, 8'd0, 8'h3C, 8'hC3, 2'd2);
        xfer("m3", 1'b1, 1'b1, 8'd3, 8'h3C, 8'hC3, 2'd3);
        check_eq("m3 mosi idle", MOSI3, 1'b0);

        // Back-to-back: start held high through the done cycle.
        @(negedge clock);
        cpol = 1'b0; cpha = 1'b0; clock_div = 8'd0; dataToTransmit = 8'h5A; ss_sel = 2'd2;
        cpol_tb = 1'b0; cpha_tb = 1'b0; slv_tx = 8'hA5;
        start = 1'b1;
        @(posedge clock); #1;
        wait_done(4'b1011, n, bad);
        check_eq("b2b first latency", n, 19);
        check_eq("b2b first rx", dataRecieved, 8'hA5);
        check_eq("b2b gap ss_n", ss_n, 4'hF);
        check_eq("b2b gap busy", busy, 1'b0);
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("b2b restart busy", busy, 1'b1);
        wait_done(4'b1011, n, bad);
        check_eq("b2b second latency", n, 19);
        check_eq("b2b second rx", dataRecieved, 8'hA5);
        check_eq("b2b second slave", s_in, 8'h5A);
        check_eq("b2b ss_n", bad, 0);

        // Reset in the middle of TRANSFER.
        @(negedge clock);
        cpol = 1'b1; cpha = 1'b0; clock_div = 8'd2; dataToTransmit = 8'hF0; ss_sel = 2'd1;
        cpol_tb = 1'b1; cpha_tb = 1'b0; slv_tx = 8'h0F;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        check_eq("mid busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid rst ss_n", ss_n, 4'hF);
        check_eq("mid rst busy", busy, 1'b0);
        check_eq("mid rst sclk", sclk, 1'b0);
        check_eq("mid rst mosi", MOSI, 1'b0);
        check_eq("mid rst data", dataRecieved, 8'h00);
        @(negedge clock);
        reset = 1'b0;

`ifdef SPI_LSB_FIRST_EN
        @(negedge clock);
        cpol = 1'b0; cpha = 1'b0; clock_div = 8'd1; dataToTransmit = 8'h01; ss_sel = 2'd0;
        lsb_first = 1'b1;
        cpol_tb = 1'b0; cpha_tb = 1'b0; lsb_tb = 1'b1; slv_tx = 8'h80;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_eq("lsb first bit", MOSI, 1'b1);
        wait_done(4'b1110, n, bad);
        check_eq("lsb latency", n, 37);
        check_eq("lsb rx", dataRecieved, 8'h80);
        check_eq("lsb slave rx", s_in, 8'h01);
        lsb_first = 1'b0;
        lsb_tb = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_master_multi
